buzzer_scheduler: RTL and testbench

Sequences the shared buzzer driver of the quiz responder. It accepts one-cycle event pulses (answer accepted, countdown warning, time over) and turns them into timed beep patterns on the driver's Buzzer_Enable (answer tone) and Buzzer_TimeOver (time-over tone) inputs. When requests collide it arbitrates by fixed priority with preemption, and it queues lower-priority requests. It sits between the game-control FSM and the buzzer tone generator.

---
 rtl/buzzer_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_buzzer_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_scheduler.sv
// Buzzer pattern sequencer: turns answer/warn/time-over event pulses into timed
// beep patterns with fixed-priority preemption (TO > ANS > WARN) and pending queueing.
module buzzer_scheduler #(
    parameter int TICK_DIV  = 50000,
    parameter int ANS_ON    = 300,
    parameter int WARN_ON   = 100,
    parameter int TO_ON     = 200,
    parameter int TO_OFF    = 200,
    parameter int TO_REPEAT = 3,
    parameter int GAP       = 50,
    parameter int CW        = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Answer_Req,
    input  logic       Warn_Req,
    input  logic       TimeOver_Req,
    input  logic       Mute,
    output logic       Buzzer_Enable,
    output logic       Buzzer_TimeOver,
    output logic       Busy,
    output logic [1:0] Active_Src,
    output logic       Pattern_Done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_WARN = 2'd1;
    localparam logic [1:0] SRC_ANS  = 2'd2;
    localparam logic [1:0] SRC_TO   = 2'd3;

    typedef enum logic [1:0] {IDLE, ON, OFF, GUARD} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [CW-1:0] tick, tick_n;
    logic [CW-1:0] beeps, beeps_n;
    logic [CW-1:0] cur_len;
    logic [1:0]    src, src_n;
    logic [2:0]    pend, pend_n;   // bit 2 = TO, bit 1 = ANS, bit 0 = WARN
    logic          tone_ans, tone_ans_n;
    logic          tone_to, tone_to_n;
    logic [2:0]    req, cand;
    logic [1:0]    grant;
    logic          phase_end, preempt;

    function automatic logic [2:0] lvl_mask(input logic [1:0] lvl);
        case (lvl)
            SRC_WARN: return 3'b001;
            SRC_ANS:  return 3'b010;
            SRC_TO:   return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] top_lvl(input logic [2:0] v);
        if (v[2])      return SRC_TO;
        else if (v[1]) return SRC_ANS;
        else if (v[0]) return SRC_WARN;
        else           return SRC_NONE;
    endfunction

    assign req     = {TimeOver_Req, Answer_Req, Warn_Req};
    assign cand    = pend | req;
    assign grant   = top_lvl(cand);
    assign preempt = top_lvl(req) > src;

    always_comb begin
        cur_len = '0;
        case (state)
            ON:      cur_len = (src == SRC_TO)  ? CW'(TO_ON)  :
                               (src == SRC_ANS) ? CW'(ANS_ON) : CW'(WARN_ON);
            OFF:     cur_len = CW'(TO_OFF);
            GUARD:   cur_len = CW'(GAP);
            default: cur_len = '0;
        endcase
    end

    // A zero-length phase still occupies one cycle.
    assign phase_end = (cur_len == '0) ||
                       ((pre == PRE_LAST) && (tick == cur_len - CW'(1)));

    always_comb begin
        state_n      = state;
        src_n        = src;
        beeps_n      = beeps;
        pend_n       = pend | (req & ~lvl_mask(src));
        Pattern_Done = 1'b0;
        if (pre == PRE_LAST) begin
            pre_n  = '0;
            tick_n = tick + CW'(1);
        end else begin
            pre_n  = pre + PW'(1);
            tick_n = tick;
        end

        case (state)
            IDLE: begin
                pre_n  = '0;
                tick_n = '0;
                if (cand != 3'b000) begin
                    src_n   = grant;
                    pend_n  = cand & ~lvl_mask(grant);
                    beeps_n = (grant == SRC_TO) ? CW'(TO_REPEAT) : CW'(1);
                    state_n = ON;
                end
            end
            ON: begin
                // Natural completion wins over a same-cycle preemption.
                if (phase_end && beeps <= CW'(1)) begin
                    Pattern_Done = 1'b1;
                    src_n        = SRC_NONE;
                    state_n      = GUARD;
                    pre_n        = '0;
                    tick_n       = '0;
                end else if (preempt) begin
                    src_n   = SRC_NONE;
                    state_n = GUARD;
                    pre_n   = '0;
                    tick_n  = '0;
                end else if (phase_end) begin
                    beeps_n = beeps - CW'(1);
                    state_n = OFF;
                    pre_n   = '0;
                    tick_n  = '0;
                end
            end
            OFF: begin
                if (preempt) begin
                    src_n   = SRC_NONE;
                    state_n = GUARD;
                    pre_n   = '0;
                    tick_n  = '0;
                end else if (phase_end) begin
                    state_n = ON;
                    pre_n   = '0;
                    tick_n  = '0;
                end
            end
            GUARD: begin
                if (phase_end) begin
                    state_n = IDLE;
                    pre_n   = '0;
                    tick_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        tone_ans_n = (state_n == ON) && (src_n == SRC_ANS);
        tone_to_n  = (state_n == ON) && ((src_n == SRC_TO) || (src_n == SRC_WARN));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            pre      <= '0;
            tick     <= '0;
            beeps    <= '0;
            src      <= SRC_NONE;
            pend     <= 3'b000;
            tone_ans <= 1'b0;
            tone_to  <= 1'b0;
        end else begin
            state    <= state_n;
            pre      <= pre_n;
            tick     <= tick_n;
            beeps    <= beeps_n;
            src      <= src_n;
            pend     <= pend_n;
            tone_ans <= tone_ans_n;
            tone_to  <= tone_to_n;
        end
    end

    assign Buzzer_Enable   = tone_ans & ~Mute;
    assign Buzzer_TimeOver = tone_to & ~Mute;
    assign Busy            = (state != IDLE);
    assign Active_Src      = src;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler: directed scenarios plus random traffic, every cycle
// compared against a phase/remaining-cycles reference model.
module tb_buzzer_scheduler;

    localparam int TD   = 4;
    localparam int ANS  = 3;
    localparam int WARN = 1;
    localparam int TON  = 2;
    localparam int TOFF = 2;
    localparam int REP  = 3;
    localparam int GAPP = 1;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Answer_Req, Warn_Req, TimeOver_Req, Mute;
    logic       Buzzer_Enable, Buzzer_TimeOver, Busy, Pattern_Done;
    logic [1:0] Active_Src;

    buzzer_scheduler #(
        .TICK_DIV(TD), .ANS_ON(ANS), .WARN_ON(WARN), .TO_ON(TON),
        .TO_OFF(TOFF), .TO_REPEAT(REP), .GAP(GAPP), .CW(16)
    ) dut (
        .CLK(CLK), .RST(RST), .Answer_Req(Answer_Req), .Warn_Req(Warn_Req),
        .TimeOver_Req(TimeOver_Req), .Mute(Mute), .Buzzer_Enable(Buzzer_Enable),
        .Buzzer_TimeOver(Buzzer_TimeOver), .Busy(Busy), .Active_Src(Active_Src),
        .Pattern_Done(Pattern_Done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: phase 0 idle, 1 on, 2 off, 3 guard; rem = cycles left in phase.
    int         m_phase, m_rem, m_src, m_beeps;
    logic [2:0] m_pend;

    logic o_en, o_to, o_busy, o_done;
    logic [1:0] o_src;
    int n_en, n_to, n_done, n_ovl, n_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int onlen(input int s);
        if (s == 3)      return TON * TD;
        else if (s == 2) return ANS * TD;
        else             return WARN * TD;
    endfunction

    function automatic int guard_len();
        return (GAPP * TD > 0) ? GAPP * TD : 1;
    endfunction

    function automatic logic [2:0] onehot(input int s);
        logic [2:0] one;
        one = 3'b001;
        if (s == 0) return 3'b000;
        return one << (s - 1);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_src = 0; m_beeps = 0; m_pend = 3'b000;
    endtask

    task automatic model_update(input logic [2:0] rq);
        logic [2:0] c;
        int g, hi;
        bit nat;
        if (m_phase == 0) begin
            c = m_pend | rq;
            if (c != 3'b000) begin
                g = c[2] ? 3 : (c[1] ? 2 : 1);
                m_pend  = c & ~onehot(g);
                m_src   = g;
                m_beeps = (g == 3) ? REP : 1;
                m_phase = 1;
                m_rem   = onlen(g);
            end
        end else begin
            hi  = rq[2] ? 3 : (rq[1] ? 2 : (rq[0] ? 1 : 0));
            nat = (m_phase == 1) && (m_rem == 1) && (m_beeps == 1);
            m_pend = m_pend | (rq & ~onehot(m_src));
            if (nat || ((m_phase == 1 || m_phase == 2) && hi > m_src)) begin
                m_src = 0; m_phase = 3; m_rem = guard_len();
            end else if (m_rem == 1) begin
                case (m_phase)
                    1: begin m_beeps--; m_phase = 2; m_rem = TOFF * TD; end
                    2: begin m_phase = 1; m_rem = onlen(m_src); end
                    default: begin m_phase = 0; m_rem = 0; end
                endcase
            end else begin
                m_rem--;
            end
        end
    endtask

    task automatic clr_counts();
        n_en = 0; n_to = 0; n_done = 0; n_ovl = 0; n_busy = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then clock both.
    task automatic step(input logic [2:0] rq, input logic mu);
        logic e_en, e_to, e_busy, e_done;
        @(negedge CLK);
        TimeOver_Req = rq[2]; Answer_Req = rq[1]; Warn_Req = rq[0]; Mute = mu;
        #1;
        o_en = Buzzer_Enable; o_to = Buzzer_TimeOver; o_busy = Busy;
        o_src = Active_Src; o_done = Pattern_Done;
        e_en   = (m_phase == 1) && (m_src == 2) && !mu;
        e_to   = (m_phase == 1) && (m_src == 1 || m_src == 3) && !mu;
        e_busy = (m_phase != 0);
        e_done = (m_phase == 1) && (m_rem == 1) && (m_beeps == 1);
        chk("enable", o_en, e_en);
        chk("timeover", o_to, e_to);
        chk("busy", o_busy, e_busy);
        chk("active_src", o_src, m_src[1:0]);
        chk("pattern_done", o_done, e_done);
        if (o_en) n_en++;
        if (o_to) n_to++;
        if (o_done) n_done++;
        if (o_busy) n_busy++;
        if (o_en && o_to) n_ovl++;
        @(posedge CLK);
        model_update(rq);
        cyc++;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 1'b0);
    endtask

    initial begin
        RST = 1'b1; Answer_Req = 0; Warn_Req = 0; TimeOver_Req = 0; Mute = 0;
        model_reset();
        #12;
        chk("rst_enable", Buzzer_Enable, 1'b0);
        chk("rst_timeover", Buzzer_TimeOver, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_src", Active_Src, 2'd0);
        chk("rst_done", Pattern_Done, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        run_idle(3);

        // Answer alone: enable high cycles 1..12, done on 12, guard 13..16, idle at 17.
        clr_counts();
        for (int k = 0; k < 20; k++) begin
            step((k == 0) ? 3'b010 : 3'b000, 1'b0);
            chk("ans_en_abs", o_en, (k >= 1 && k <= 12));
            chk("ans_done_abs", o_done, (k == 12));
            chk("ans_busy_abs", o_busy, (k >= 1 && k <= 16));
        end

        // Time-over alone: three 8-cycle beeps separated by 8-cycle silences.
        clr_counts();
        step(3'b100, 1'b0);
        for (int k = 1; k < 50; k++) begin
            step(3'b000, 1'b0);
            chk("to_wave_abs", o_to, (k >= 1 && k <= 40) && (((k - 1) / 8) % 2 == 0));
            chk("to_src_abs", o_src, (k >= 1 && k <= 40) ? 2'd3 : 2'd0);
        end
        chk("to_beep_cycles", n_to, 24);
        chk("to_done_count", n_done, 1);

        // All three at once: TO, then answer, then warn.
        clr_counts();
        step(3'b111, 1'b0);
        run_idle(90);
        chk("all3_done_count", n_done, 3);
        chk("all3_overlap", n_ovl, 0);
        chk("all3_en_cycles", n_en, 12);
        chk("all3_to_cycles", n_to, 28);

        // Answer preempted at tick 1 by time-over; answer not replayed.
        clr_counts();
        for (int k = 0; k < 70; k++) step((k == 0) ? 3'b010 : (k == 5) ? 3'b100 : 3'b000, 1'b0);
        chk("pre_en_cycles", n_en, 5);
        chk("pre_done_count", n_done, 1);
        chk("pre_to_cycles", n_to, 24);

        // Warn preempted by answer.
        clr_counts();
        for (int k = 0; k < 30; k++) step((k == 0) ? 3'b001 : (k == 2) ? 3'b010 : 3'b000, 1'b0);
        chk("wpre_done_count", n_done, 1);
        chk("wpre_en_cycles", n_en, 12);
        chk("wpre_to_cycles", n_to, 2);

        // Warn during answer waits until the answer completes.
        clr_counts();
        for (int k = 0; k < 40; k++) step((k == 0) ? 3'b010 : (k == 3) ? 3'b001 : 3'b000, 1'b0);
        chk("queue_done_count", n_done, 2);
        chk("queue_en_cycles", n_en, 12);
        chk("queue_to_cycles", n_to, 4);

        // Muted time-over pattern: silent outputs, unchanged timing.
        clr_counts();
        step(3'b100, 1'b1);
        for (int k = 1; k < 50; k++) step(3'b000, 1'b1);
        chk("mute_to_cycles", n_to, 0);
        chk("mute_done_count", n_done, 1);
        chk("mute_busy_cycles", n_busy, 44);

        // Reset mid-beep with lower-priority requests pending.
        for (int k = 0; k < 20; k++) step((k == 0) ? 3'b100 : (k == 3) ? 3'b001 : (k == 4) ? 3'b010 : 3'b000, 1'b0);
        @(negedge CLK);
        #1;
        chk("prerst_timeover", Buzzer_TimeOver, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_timeover", Buzzer_TimeOver, 1'b0);
        chk("async_rst_enable", Buzzer_Enable, 1'b0);
        chk("async_rst_busy", Busy, 1'b0);
        chk("async_rst_src", Active_Src, 2'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        clr_counts();
        run_idle(20);
        chk("rst_pending_lost", n_busy, 0);

        // Random traffic against the model.
        begin
            logic mu;
            logic [2:0] rq;
            mu = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                rq[0] = ($urandom_range(0, 29) == 0);
                rq[1] = ($urandom_range(0, 29) == 0);
                rq[2] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 49) == 0) mu = ~mu;
                step(rq, mu);
                chk("rand_no_overlap", (o_en && o_to), 1'b0);
            end
        end
        run_idle(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
